// File: rtl/fp_pkg.sv
// Shared definitions for the FP add/sub datapath: default single-precision widths,
// a constant-evaluable clog2 and the normalise-stage result record.
package fp_pkg;

    localparam int unsigned MW_SP = 23;
    localparam int unsigned EW_SP = 8;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    typedef struct packed {
        logic [MW_SP-1:0] frac;
        logic [EW_SP:0]   exp;
        logic             r;
        logic             s;
        logic             zero;
        logic             neg;
        logic             subn;
    } normRes_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter, scanning from the MSB down, with an all-zero flag.
// The count equals W when the input is all zero.
module fp_lzc #(
    parameter int unsigned W  = 25,
    parameter int unsigned CW = 5
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count,
    output logic          allZero
);

    logic found;

    always_comb begin
        count = '0;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found) begin
                if (value[i]) begin
                    found = 1'b1;
                end else begin
                    count = count + CW'(1);
                end
            end
        end
        allZero = ~found;
    end

endmodule

// File: rtl/fp_norm_shift_pipe.sv
// Two-stage normalise for FP add/sub: stage 1 counts leading zeros, stage 2 shifts,
// adjusts the exponent and extracts fraction/round/sticky. Whole pipe stalls on back-pressure.
module fp_norm_shift_pipe
    import fp_pkg::*;
#(
    parameter int unsigned MW    = MW_SP,
    parameter int unsigned EW    = EW_SP,
    parameter int unsigned CLAMP = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW+2:0] in_sum,
    input  logic          in_sticky,
    input  logic [EW-1:0] in_exp,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] out_frac,
    output logic [EW:0]   out_exp,
    output logic          out_r,
    output logic          out_s,
    output logic          out_zero,
    output logic          out_neg,
    output logic          out_subn
);

    localparam int unsigned SW = clog2(MW + 3);

    typedef struct packed {
        logic [MW-1:0] frac;
        logic [EW:0]   exp;
        logic          r;
        logic          s;
        logic          zero;
        logic          neg;
        logic          subn;
    } res_t;

    logic          v1;
    logic          v2;
    logic          adv1;
    logic          adv2;

    logic [MW+2:0] sum1;
    logic          sticky1;
    logic [EW-1:0] exp1;
    logic          zero1;
    logic [SW-1:0] lz1;

    logic [SW-1:0] lzCount;
    logic          lzcZero;
    logic          zeroIn;

    res_t          resD;
    res_t          resQ;
    logic [SW-1:0] sh;
    logic [MW+1:0] shifted;
    logic [EW:0]   lzExt;

    assign adv2     = ~v2 | out_ready;
    assign adv1     = ~v1 | adv2;
    assign in_ready = adv1;

    fp_lzc #(
        .W  (MW + 2),
        .CW (SW)
    ) u_lzc (
        .value   (in_sum[MW+1:0]),
        .count   (lzCount),
        .allZero (lzcZero)
    );

    // The carry bit is outside the counted field but still makes the sum non-zero.
    assign zeroIn = lzcZero & ~in_sum[MW+2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            sum1    <= '0;
            sticky1 <= 1'b0;
            exp1    <= '0;
            zero1   <= 1'b0;
            lz1     <= '0;
        end else if (adv1) begin
            v1      <= in_valid;
            sum1    <= in_sum;
            sticky1 <= in_sticky;
            exp1    <= in_exp;
            zero1   <= zeroIn;
            lz1     <= lzCount;
        end
    end

    assign lzExt = (EW + 1)'(lz1);

    always_comb begin
        resD    = '0;
        sh      = '0;
        shifted = '0;
        if (zero1) begin
            resD.zero = 1'b1;
        end else if (sum1[MW+2]) begin
            resD.frac = sum1[MW+1:2];
            resD.r    = sum1[1];
            resD.s    = sum1[0] | sticky1;
            resD.exp  = {1'b0, exp1} + (EW + 1)'(1);
        end else begin
            sh       = lz1;
            resD.exp = {1'b0, exp1} - lzExt;
            resD.neg = resD.exp[EW];
            // Clamped: stop the shift where the biased exponent would reach zero.
            if (CLAMP != 0 && lzExt >= {1'b0, exp1}) begin
                sh        = (exp1 == '0) ? '0 : SW'(exp1 - EW'(1));
                resD.exp  = '0;
                resD.subn = 1'b1;
                resD.neg  = 1'b0;
            end
            shifted   = sum1[MW+1:0] << sh;
            resD.frac = shifted[MW:1];
            resD.r    = shifted[0];
            resD.s    = sticky1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2   <= 1'b0;
            resQ <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                resQ <= resD;
            end
        end
    end

    assign out_valid = v2;
    assign out_frac  = resQ.frac;
    assign out_exp   = resQ.exp;
    assign out_r     = resQ.r;
    assign out_s     = resQ.s;
    assign out_zero  = resQ.zero;
    assign out_neg   = resQ.neg;
    assign out_subn  = resQ.subn;

endmodule

// File: tb/tb_fp_norm_shift_pipe.sv
// Directed bench for fp_norm_shift_pipe: one unclamped and one clamped instance share
// the same stimulus; expected values are hand-derived constants.
module tb_fp_norm_shift_pipe;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic [25:0] inSum;
    logic        inSticky;
    logic [7:0]  inExp;
    logic        outReady;

    logic        inReady;
    logic        outValid;
    logic [22:0] outFrac;
    logic [8:0]  outExp;
    logic        outR, outS, outZero, outNeg, outSubn;

    logic        cReady;
    logic        cValid;
    logic [22:0] cFrac;
    logic [8:0]  cExp;
    logic        cR, cS, cZero, cNeg, cSubn;

    int          nChecks;
    int          nErrors;

    fp_norm_shift_pipe #(
        .MW    (23),
        .EW    (8),
        .CLAMP (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_sum    (inSum),
        .in_sticky (inSticky),
        .in_exp    (inExp),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_frac  (outFrac),
        .out_exp   (outExp),
        .out_r     (outR),
        .out_s     (outS),
        .out_zero  (outZero),
        .out_neg   (outNeg),
        .out_subn  (outSubn)
    );

    fp_norm_shift_pipe #(
        .MW    (23),
        .EW    (8),
        .CLAMP (1)
    ) dutClamp (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (cReady),
        .in_sum    (inSum),
        .in_sticky (inSticky),
        .in_exp    (inExp),
        .out_valid (cValid),
        .out_ready (outReady),
        .out_frac  (cFrac),
        .out_exp   (cExp),
        .out_r     (cR),
        .out_s     (cS),
        .out_zero  (cZero),
        .out_neg   (cNeg),
        .out_subn  (cSubn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] want);
        nChecks++;
        if (got !== want) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Present one beat, then confirm the two-cycle latency with out_ready high.
    task automatic runBeat(input logic [25:0] sum, input logic [7:0] e, input logic st);
        @(negedge clk);
        checkEq("in_ready", 64'(inReady), 64'd1);
        inValid  = 1'b1;
        inSum    = sum;
        inExp    = e;
        inSticky = st;
        @(negedge clk);
        inValid = 1'b0;
        checkEq("lat1_valid", 64'(outValid), 64'd0);
        @(negedge clk);
        checkEq("lat2_valid", 64'(outValid), 64'd1);
    endtask

    int          inIdx;
    int          outIdx;
    logic        held;
    logic        sawNotReady;
    logic        stale;
    logic [22:0] heldFrac;
    logic [8:0]  heldExp;

    initial begin
        nChecks  = 0;
        nErrors  = 0;
        inValid  = 1'b0;
        inSum    = '0;
        inExp    = '0;
        inSticky = 1'b0;
        outReady = 1'b1;
        rst      = 1'b0;
        #1 rst = 1'b1;
        #2;
        checkEq("rst_valid", 64'(outValid), 64'd0);
        checkEq("rst_in_ready", 64'(inReady), 64'd1);
        checkEq("rst_frac", 64'(outFrac), 64'd0);
        checkEq("rst_exp", 64'(outExp), 64'd0);
        checkEq("rst_zero", 64'(outZero), 64'd0);
        checkEq("rst_c_valid", 64'(cValid), 64'd0);
        checkEq("rst_c_subn", 64'(cSubn), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Carry: right shift by one.
        runBeat(26'h2000001, 8'h80, 1'b0);
        checkEq("carry_exp", 64'(outExp), 64'h081);
        checkEq("carry_frac", 64'(outFrac), 64'h0);
        checkEq("carry_r", 64'(outR), 64'd0);
        checkEq("carry_s", 64'(outS), 64'd1);
        checkEq("carry_neg", 64'(outNeg), 64'd0);

        // Carry at max exponent: overflow bit set, round bit from sum[1].
        runBeat(26'h3000006, 8'hFF, 1'b0);
        checkEq("ovf_exp", 64'(outExp), 64'h100);
        checkEq("ovf_frac", 64'(outFrac), 64'h400001);
        checkEq("ovf_r", 64'(outR), 64'd1);
        checkEq("ovf_s", 64'(outS), 64'd0);
        checkEq("ovf_neg", 64'(outNeg), 64'd0);

        // Left shift by 3.
        runBeat(26'h0200000, 8'h10, 1'b0);
        checkEq("sh3_exp", 64'(outExp), 64'h00D);
        checkEq("sh3_frac", 64'(outFrac), 64'h0);
        checkEq("sh3_r", 64'(outR), 64'd0);
        checkEq("sh3_s", 64'(outS), 64'd0);
        checkEq("sh3_neg", 64'(outNeg), 64'd0);

        // Left shift by 23 with sticky carried through.
        runBeat(26'h0000003, 8'h40, 1'b1);
        checkEq("sh23_exp", 64'(outExp), 64'h029);
        checkEq("sh23_frac", 64'(outFrac), 64'h400000);
        checkEq("sh23_r", 64'(outR), 64'd0);
        checkEq("sh23_s", 64'(outS), 64'd1);

        // Zero sum.
        runBeat(26'h0, 8'h55, 1'b1);
        checkEq("zero_flag", 64'(outZero), 64'd1);
        checkEq("zero_exp", 64'(outExp), 64'h0);
        checkEq("zero_frac", 64'(outFrac), 64'h0);
        checkEq("zero_r", 64'(outR), 64'd0);
        checkEq("zero_s", 64'(outS), 64'd0);

        // Underflow: wraps unclamped, goes subnormal when clamped.
        runBeat(26'h0200000, 8'h02, 1'b0);
        checkEq("uf_neg", 64'(outNeg), 64'd1);
        checkEq("uf_exp", 64'(outExp), 64'h1FF);
        checkEq("uf_subn", 64'(outSubn), 64'd0);
        checkEq("uf_c_subn", 64'(cSubn), 64'd1);
        checkEq("uf_c_exp", 64'(cExp), 64'h0);
        checkEq("uf_c_frac", 64'(cFrac), 64'h200000);
        checkEq("uf_c_neg", 64'(cNeg), 64'd0);

        // Back-pressure: 4 beats, out_ready low for cycles 2..4.
        inIdx       = 0;
        outIdx      = 0;
        held        = 1'b0;
        sawNotReady = 1'b0;
        heldFrac    = '0;
        heldExp     = '0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            outReady = !(cyc >= 2 && cyc <= 4);
            if (inIdx < 4) begin
                inValid  = 1'b1;
                inSum    = 26'h1000000 | 26'(inIdx * 2);
                inExp    = 8'(16 + inIdx);
                inSticky = 1'b0;
            end else begin
                inValid = 1'b0;
            end
            #1;
            if (!inReady) sawNotReady = 1'b1;
            if (outValid) begin
                if (held) begin
                    checkEq("hold_frac", 64'(outFrac), 64'(heldFrac));
                    checkEq("hold_exp", 64'(outExp), 64'(heldExp));
                end
                if (outReady) begin
                    checkEq("bp_frac", 64'(outFrac), 64'(outIdx));
                    checkEq("bp_exp", 64'(outExp), 64'(16 + outIdx));
                    outIdx++;
                    held = 1'b0;
                end else begin
                    held     = 1'b1;
                    heldFrac = outFrac;
                    heldExp  = outExp;
                end
            end
            if (inValid && inReady) inIdx++;
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        checkEq("bp_count", 64'(outIdx), 64'd4);
        checkEq("bp_in_ready_drop", 64'(sawNotReady), 64'd1);

        // Reset with two beats in flight.
        @(negedge clk);
        inValid = 1'b1;
        inSum   = 26'h1000002;
        inExp   = 8'h30;
        @(negedge clk);
        inSum = 26'h1000004;
        inExp = 8'h31;
        @(negedge clk);
        inValid = 1'b0;
        #1;
        checkEq("pre_rst_valid", 64'(outValid), 64'd1);
        #1 rst = 1'b1;
        #1;
        checkEq("mid_rst_valid", 64'(outValid), 64'd0);
        checkEq("mid_rst_frac", 64'(outFrac), 64'h0);
        checkEq("mid_rst_exp", 64'(outExp), 64'h0);
        checkEq("mid_rst_c_valid", 64'(cValid), 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (outValid || cValid) stale = 1'b1;
        end
        checkEq("no_stale", 64'(stale), 64'd0);
        checkEq("rdy_after_rst", 64'(inReady), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
